// File: rtl/ldpc_cnu_serial.sv
// Serial offset-min-sum check-node unit: collects one row of variable-to-check
// messages, then streams the check-to-variable messages back while the next row collects.
module ldpc_cnu_serial #(
  parameter int ROW_WEIGHT = 24,
  parameter int LLR_WIDTH  = 8,
  parameter int OFFSET     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [LLR_WIDTH-1:0]          in_data,
  output logic                          out_valid,
  output logic [LLR_WIDTH-1:0]          out_data,
  output logic [$clog2(ROW_WEIGHT)-1:0] out_idx,
  output logic                          out_last
);

  localparam int IW = $clog2(ROW_WEIGHT);
  localparam int MW = LLR_WIDTH - 1;
  localparam logic [MW-1:0] MAG_MAX  = {MW{1'b1}};
  localparam logic [MW-1:0] OFF      = MW'(OFFSET);
  localparam logic [IW-1:0] LAST_POS = IW'(ROW_WEIGHT - 1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  // The most negative code has no positive twin, so it saturates to MAG_MAX.
  function automatic logic [MW-1:0] sat_mag(input logic [LLR_WIDTH-1:0] x);
    logic [LLR_WIDTH-1:0] neg;
    neg = ~x + LLR_WIDTH'(1);
    if (x[LLR_WIDTH-1] == 1'b0) begin
      sat_mag = x[MW-1:0];
    end else if (x[MW-1:0] == {MW{1'b0}}) begin
      sat_mag = MAG_MAX;
    end else begin
      sat_mag = neg[MW-1:0];
    end
  endfunction

  function automatic logic [MW-1:0] offset_sub(input logic [MW-1:0] mag);
    if (mag > OFF) begin
      offset_sub = mag - OFF;
    end else begin
      offset_sub = {MW{1'b0}};
    end
  endfunction

  function automatic logic [LLR_WIDTH-1:0] apply_sign(input logic sign, input logic [MW-1:0] mag);
    logic [LLR_WIDTH-1:0] ext;
    ext = {1'b0, mag};
    if (sign) begin
      apply_sign = ~ext + LLR_WIDTH'(1);
    end else begin
      apply_sign = ext;
    end
  endfunction

  // Collection state
  logic [IW-1:0]         in_cnt;
  logic [MW-1:0]         min1, min2;
  logic [IW-1:0]         idx1;
  logic                  sign_acc;
  logic [ROW_WEIGHT-1:0] sign_vec;

  // Emission bank and FSM
  logic [MW-1:0]         b_min1, b_min2;
  logic [IW-1:0]         b_idx1;
  logic                  b_sign_acc;
  logic [ROW_WEIGHT-1:0] b_sign_vec;
  state_t                state;
  logic [IW-1:0]         out_cnt;

  logic                  m_sign;
  logic [MW-1:0]         m_mag;
  logic [MW-1:0]         nxt_min1, nxt_min2;
  logic [IW-1:0]         nxt_idx1;
  logic                  nxt_sign_acc;
  logic [ROW_WEIGHT-1:0] nxt_sign_vec;
  logic                  row_close;
  logic [MW-1:0]         sel_mag;
  logic [LLR_WIDTH-1:0]  emit_data;

  // Running two-minimum update including the message on in_data this cycle.
  always_comb begin
    m_sign       = in_data[LLR_WIDTH-1];
    m_mag        = sat_mag(in_data);
    nxt_min1     = min1;
    nxt_min2     = min2;
    nxt_idx1     = idx1;
    if (m_mag < min1) begin
      nxt_min2 = min1;
      nxt_min1 = m_mag;
      nxt_idx1 = in_cnt;
    end else if (m_mag < min2) begin
      nxt_min2 = m_mag;
    end else begin
      nxt_min2 = min2;
    end
    nxt_sign_acc         = sign_acc ^ m_sign;
    nxt_sign_vec         = sign_vec;
    nxt_sign_vec[in_cnt] = m_sign;
    row_close            = in_valid && (in_cnt == LAST_POS);
  end

  // Collection registers; idle cycles hold everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt   <= {IW{1'b0}};
      min1     <= MAG_MAX;
      min2     <= MAG_MAX;
      idx1     <= {IW{1'b0}};
      sign_acc <= 1'b0;
      sign_vec <= {ROW_WEIGHT{1'b0}};
    end else if (in_valid) begin
      if (row_close) begin
        in_cnt   <= {IW{1'b0}};
        min1     <= MAG_MAX;
        min2     <= MAG_MAX;
        idx1     <= {IW{1'b0}};
        sign_acc <= 1'b0;
        sign_vec <= {ROW_WEIGHT{1'b0}};
      end else begin
        in_cnt   <= in_cnt + IW'(1);
        min1     <= nxt_min1;
        min2     <= nxt_min2;
        idx1     <= nxt_idx1;
        sign_acc <= nxt_sign_acc;
        sign_vec <= nxt_sign_vec;
      end
    end
  end

  // Emission bank: loaded only at row close with the final row summary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_min1     <= MAG_MAX;
      b_min2     <= MAG_MAX;
      b_idx1     <= {IW{1'b0}};
      b_sign_acc <= 1'b0;
      b_sign_vec <= {ROW_WEIGHT{1'b0}};
    end else if (row_close) begin
      b_min1     <= nxt_min1;
      b_min2     <= nxt_min2;
      b_idx1     <= nxt_idx1;
      b_sign_acc <= nxt_sign_acc;
      b_sign_vec <= nxt_sign_vec;
    end
  end

  // Extrinsic message for position out_cnt: exclude own contribution.
  always_comb begin
    if (out_cnt == b_idx1) begin
      sel_mag = b_min2;
    end else begin
      sel_mag = b_min1;
    end
    emit_data = apply_sign(b_sign_acc ^ b_sign_vec[out_cnt], offset_sub(sel_mag));
  end

  // Emission FSM with registered outputs; a row close on the last emit cycle chains rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_cnt   <= {IW{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {LLR_WIDTH{1'b0}};
      out_idx   <= {IW{1'b0}};
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_cnt   <= {IW{1'b0}};
          if (row_close) begin
            state <= EMIT;
          end
        end
        EMIT: begin
          out_valid <= 1'b1;
          out_data  <= emit_data;
          out_idx   <= out_cnt;
          out_last  <= (out_cnt == LAST_POS);
          if (out_cnt == LAST_POS) begin
            out_cnt <= {IW{1'b0}};
            state   <= row_close ? EMIT : IDLE;
          end else begin
            out_cnt <= out_cnt + IW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          out_cnt   <= {IW{1'b0}};
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_cnu_serial.sv
// Scoreboard bench for ldpc_cnu_serial: stimulus pushes expected messages, a
// negedge monitor pops and compares whenever out_valid is high.
module tb_ldpc_cnu_serial;

  localparam int RW  = 24;
  localparam int W   = 8;
  localparam int OFF = 1;

  typedef struct packed {
    logic [W-1:0] data;
    logic [4:0]   idx;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [4:0]   out_idx;
  logic         out_last;

  exp_t         exp_q[$];
  logic [W-1:0] row[RW];
  int           errors = 0;
  int           checks = 0;
  int           cur_run = 0;
  int           last_run = 0;

  ldpc_cnu_serial #(.ROW_WEIGHT(RW), .LLR_WIDTH(W), .OFFSET(OFF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  function automatic int amag(input logic [W-1:0] v);
    int s;
    s = int'($signed(v));
    if (s == -128) return 127;
    return (s < 0) ? -s : s;
  endfunction

  // Reference: min magnitude and sign product over every other position.
  function automatic logic [W-1:0] ref_out(input int j);
    int m;
    logic s;
    m = 1000;
    s = 1'b0;
    for (int k = 0; k < RW; k++) begin
      if (k != j) begin
        if (amag(row[k]) < m) m = amag(row[k]);
        s = s ^ row[k][W-1];
      end
    end
    m = m - OFF;
    if (m < 0) m = 0;
    return s ? W'(-m) : W'(m);
  endfunction

  task automatic push_model();
    exp_t e;
    for (int j = 0; j < RW; j++) begin
      e.data = ref_out(j);
      e.idx  = 5'(j);
      e.last = (j == RW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_two(input logic [W-1:0] d_rest, input int sp, input logic [W-1:0] d_sp);
    exp_t e;
    for (int j = 0; j < RW; j++) begin
      e.data = (j == sp) ? d_sp : d_rest;
      e.idx  = 5'(j);
      e.last = (j == RW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_row();
    int r;
    for (int p = 0; p < RW; p++) begin
      r = $urandom_range(9);
      if (r == 0)      row[p] = 8'h80;
      else if (r < 4)  row[p] = W'($urandom_range(6) - 3);
      else             row[p] = W'($urandom);
    end
  endtask

  task automatic drive_row(input int gap_max);
    for (int p = 0; p < RW; p++) begin
      if (gap_max > 0 && p > 0) begin
        repeat ($urandom_range(gap_max)) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = W'($urandom);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = row[p];
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cur_run = 0;
    end else if (out_valid) begin
      cur_run++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_idx", 32'(out_idx), 32'(e.idx));
        chk("sb_data", 32'(out_data), 32'(e.data));
        chk("sb_last", 32'(out_last), 32'(e.last));
      end
    end else begin
      if (cur_run != 0) last_run = cur_run;
      cur_run = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unique minimum: 23 x +10, then -3
    for (int p = 0; p < RW; p++) row[p] = 8'd10;
    row[RW-1] = 8'hFD;
    push_two(8'hFE, RW - 1, 8'd9);
    drive_row(0);
    idle_cycle();
    chk("lat_edge_n", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge_n1", {26'd0, out_valid, out_idx}, {26'd0, 1'b1, 5'd0});
    wait_drain();

    // Tied minimum with -128 saturation and offset floor: all zero
    for (int p = 0; p < RW; p++) row[p] = 8'd1;
    row[0] = 8'h80;
    row[2] = 8'hFF;
    push_two(8'd0, 0, 8'd0);
    drive_row(0);
    idle_cycle();
    wait_drain();

    // Back-to-back rows: 48 continuous outputs
    rand_row();
    push_model();
    drive_row(0);
    rand_row();
    row[5] = 8'h80;
    push_model();
    drive_row(0);
    idle_cycle();
    wait_drain();
    chk("b2b_run", 32'(last_run), 32'd48);

    // Gapped input must match the gapless result
    for (int t = 0; t < 3; t++) begin
      rand_row();
      push_model();
      drive_row(0);
      idle_cycle();
      wait_drain();
      push_model();
      drive_row(3);
      idle_cycle();
      wait_drain();
    end

    // Reset during emission at out_idx 5, with a partial next row in flight
    rand_row();
    push_model();
    drive_row(0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == 5'd5) begin
        found = 1'b1;
      end else begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
      end
    end
    chk("rst_hit_idx5", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_last", 32'(out_last), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("async_rst_idx", 32'(out_idx), 32'd0);
    rst = 1'b0;
    rand_row();
    push_model();
    drive_row(0);
    idle_cycle();
    wait_drain();

    // Random regression, rows back-to-back
    for (int r = 0; r < 1000; r++) begin
      rand_row();
      push_model();
      drive_row(0);
    end
    idle_cycle();
    wait_drain();

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
